// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg7_pkg
// Brief    : Segment glyph constants and nibble-to-glyph lookup for seg7_scan.
// Revision : 1.0
// ============================================================================
package seg7_pkg;

    // Active-low segments, bit6 = a ... bit0 = g.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h60;
    localparam logic [6:0] SEG_C     = 7'h31;
    localparam logic [6:0] SEG_D     = 7'h42;
    localparam logic [6:0] SEG_E     = 7'h30;
    localparam logic [6:0] SEG_F     = 7'h38;

    // Letters only render in hex mode; in decimal mode they read as blank.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        g = SEG_BLANK;
        case (nib)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = hex ? SEG_A : SEG_BLANK;
            4'hB: g = hex ? SEG_B : SEG_BLANK;
            4'hC: g = hex ? SEG_C : SEG_BLANK;
            4'hD: g = hex ? SEG_D : SEG_BLANK;
            4'hE: g = hex ? SEG_E : SEG_BLANK;
            4'hF: g = hex ? SEG_F : SEG_BLANK;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_if.sv
`default_nettype none
// ============================================================================
// Interface : seg7_scan_if
// Brief     : Frame write channel (valid/ready, nibbles, enable mask) into
//             seg7_scan. Carries wr_dp only when SEG7_DP_EN is defined.
// Revision  : 1.0
// ============================================================================
interface seg7_scan_if #(
    parameter int NDIGIT = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [4*NDIGIT-1:0]   wr_data;
    logic [NDIGIT-1:0]     wr_mask;
`ifdef SEG7_DP_EN
    logic [NDIGIT-1:0]     wr_dp;

    modport master (output wr_valid, output wr_data, output wr_mask, output wr_dp,
                    input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, input  wr_mask, input  wr_dp,
                    output wr_ready);
`else
    modport master (output wr_valid, output wr_data, output wr_mask,
                    input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, input  wr_mask,
                    output wr_ready);
`endif
endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Brief    : Combinational nibble to active-low 7-segment glyph decoder.
// Revision : 1.0
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_hex_mode,
    output logic [6:0] o_seg
);

    assign o_seg = seg7_glyph(i_nib, i_hex_mode);

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Brief    : Time-multiplexed common-anode 7-segment driver. Frames are
//            double-buffered and only swapped at a frame boundary; each
//            digit slot opens with a guard interval of all anodes off.
//            Optional per-digit decimal points: define SEG7_DP_EN.
// Revision : 1.0
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NDIGIT = 8,
    parameter int DIV    = 1000,
    parameter int GUARD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_if.slave        wr,
    input  logic              hex_mode,
    input  logic              lz_blank,
    output logic [6:0]        seg_o,
    output logic [NDIGIT-1:0] an_o,
    output logic              dp_o
);

    localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_idx_w = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_guard    = c_cnt_w'(GUARD);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NDIGIT - 1);

    // Scan position
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_idx_w-1:0]    r_idx;

    // Write side (pending) and display side (shown) buffers
    logic [4*NDIGIT-1:0]   r_pend_data;
    logic [NDIGIT-1:0]     r_pend_mask;
    logic                  r_pend_vld;
    logic                  r_ready;
    logic [4*NDIGIT-1:0]   r_shown;
    logic [NDIGIT-1:0]     r_mask;

    // Registered pins
    logic [6:0]            r_seg;
    logic [NDIGIT-1:0]     r_an;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_accept;
    logic                  w_pend_vld_nxt;
    logic [3:0]            w_nib [NDIGIT];
    logic [NDIGIT-1:0]     w_lzb;
    logic [3:0]            w_cur_nib;
    logic [6:0]            w_glyph;
    logic                  w_guard;
    logic                  w_en;
    logic [6:0]            w_seg_nxt;
    logic [NDIGIT-1:0]     w_an_nxt;
    logic                  w_dp_nxt;

    assign w_slot_end  = (r_cnt == c_cnt_last);
    assign w_frame_end = w_slot_end && (r_idx == c_idx_last);
    assign w_accept    = wr.wr_valid && r_ready;

    // ------------------------------------------------------------------
    // Slot / digit counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Handshake and double buffer
    // ------------------------------------------------------------------
    // Accept is only possible while nothing is pending, so accept and
    // promotion never compete for the same pending slot.
    always_comb begin
        w_pend_vld_nxt = r_pend_vld;
        if (w_accept) begin
            w_pend_vld_nxt = 1'b1;
        end else if (w_frame_end) begin
            w_pend_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_data <= '0;
            r_pend_mask <= '0;
            r_pend_vld  <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            if (w_accept) begin
                r_pend_data <= wr.wr_data;
                r_pend_mask <= wr.wr_mask;
            end
            r_pend_vld <= w_pend_vld_nxt;
            r_ready    <= !w_pend_vld_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shown <= '0;
            r_mask  <= '0;
        end else if (w_frame_end && r_pend_vld) begin
            r_shown <= r_pend_data;
            r_mask  <= r_pend_mask;
        end
    end

    assign wr.wr_ready = r_ready;

    // ------------------------------------------------------------------
    // Leading-zero detection on the shown frame
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NDIGIT; gi++) begin : g_nib
        assign w_nib[gi] = r_shown[4*gi +: 4];
    end

    // Walk from the most significant digit down; a digit is leading-zero
    // while no enabled non-zero nibble has been seen above or at it.
    always_comb begin
        logic w_seen;
        w_seen = 1'b0;
        w_lzb  = '0;
        for (int i = NDIGIT - 1; i >= 0; i--) begin
            w_seen   = w_seen | (r_mask[i] && (w_nib[i] != 4'h0));
            w_lzb[i] = lz_blank && (i != 0) && !w_seen;
        end
    end

    // ------------------------------------------------------------------
    // Current digit decode and output stage
    // ------------------------------------------------------------------
    assign w_cur_nib = w_nib[r_idx];

    seg7_decode u_decode (
        .i_nib      (w_cur_nib),
        .i_hex_mode (hex_mode),
        .o_seg      (w_glyph)
    );

    assign w_guard = (r_cnt < c_guard);
    assign w_en    = r_mask[r_idx] && !w_lzb[r_idx];

`ifdef SEG7_DP_EN
    logic [NDIGIT-1:0] r_pend_dp;
    logic [NDIGIT-1:0] r_shown_dp;
    logic              r_dp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_dp  <= '0;
            r_shown_dp <= '0;
        end else begin
            if (w_accept) begin
                r_pend_dp <= wr.wr_dp;
            end
            if (w_frame_end && r_pend_vld) begin
                r_shown_dp <= r_pend_dp;
            end
        end
    end
`endif

    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = SEG_BLANK;
        w_dp_nxt  = 1'b1;
        if (!w_guard && w_en) begin
            w_an_nxt[r_idx] = 1'b0;
            w_seg_nxt       = w_glyph;
`ifdef SEG7_DP_EN
            w_dp_nxt        = ~r_shown_dp[r_idx];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

`ifdef SEG7_DP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dp <= 1'b1;
        end else begin
            r_dp <= w_dp_nxt;
        end
    end

    assign dp_o = r_dp;
`else
    // Without decimal-point support the pin idles off; w_dp_nxt stays constant.
    logic w_dp_unused;
    assign w_dp_unused = w_dp_nxt;
    assign dp_o        = 1'b1;
`endif

    assign seg_o = r_seg;
    assign an_o  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan
// Brief    : Self-checking bench for seg7_scan (NDIGIT=4, DIV=8, GUARD=2).
// Revision : 1.0
// ============================================================================
module tb_seg7_scan;

    localparam int ND = 4;
    localparam int DV = 8;
    localparam int GD = 2;
    localparam int FR = ND * DV;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mask;
        logic        hex;
        logic        lz;
        logic [27:0] seg;   // expected glyph per digit, digit0 in [6:0]
        logic [3:0]  en;    // expected anode-enabled digits
    } vec_t;

    typedef struct {
        int   frame;
        vec_t v;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hex_mode = 1'b0;
    logic       lz_blank = 1'b0;
    logic [6:0] seg_o;
    logic [3:0] an_o;
    logic       dp_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    sb_t q[$];

    seg7_scan_if #(.NDIGIT(ND)) ifc ();

    seg7_scan #(
        .NDIGIT (ND),
        .DIV    (DV),
        .GUARD  (GD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (ifc),
        .hex_mode (hex_mode),
        .lz_blank (lz_blank),
        .seg_o    (seg_o),
        .an_o     (an_o),
        .dp_o     (dp_o)
    );

    always #5 clk = ~clk;

    // cyc = number of active edges since reset released
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: output after edge e belongs to frame (e-1)/FR,
    // slot ((e-1)/DV)%ND, slot cycle (e-1)%DV.
    int          mf, ms, mc;
    sb_t         cur;
    logic [27:0] sg;
    logic [3:0]  exp_an;

    always @(negedge clk) begin
        if (rst_n && cyc >= 1 && q.size() > 0) begin
            mf  = (cyc - 1) / FR;
            ms  = ((cyc - 1) / DV) % ND;
            mc  = (cyc - 1) % DV;
            cur = q[0];
            if (cur.frame < mf) begin
                chk("sb_frame_missed", mf, cur.frame);
                void'(q.pop_front());
            end else if (cur.frame == mf) begin
                sg     = cur.v.seg;
                exp_an = cur.v.en[ms] ? ~(4'b0001 << ms) : 4'hF;
                if (mc < GD) begin
                    chk("guard_an", an_o, 4'hF);
                    chk("guard_seg", seg_o, 7'h7F);
                end
                if (mc == GD || mc == DV - 1) begin
                    chk("slot_an", an_o, exp_an);
                    if (cur.v.en[ms]) chk("slot_seg", seg_o, sg[7*ms +: 7]);
                    chk("slot_dp", dp_o, 1'b1);
                end
                if (ms == ND - 1 && mc == DV - 1) void'(q.pop_front());
            end
        end
    end

    // Call at a negedge. Returns the edge number at which the frame was taken.
    task automatic do_write(input vec_t v, input bit push, output int acc);
        int  n;
        sb_t e;
        n   = 0;
        acc = -1;
        while (ifc.wr_ready !== 1'b1 && n < 4 * FR) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_write", ifc.wr_ready, 1'b1);
        if (ifc.wr_ready !== 1'b1) return;
        ifc.wr_valid = 1'b1;
        ifc.wr_data  = v.data;
        ifc.wr_mask  = v.mask;
        @(negedge clk);
        acc          = cyc;
        ifc.wr_valid = 1'b0;
        chk("ready_low_after_accept", ifc.wr_ready, 1'b0);
        if (push) begin
            e.frame = acc / FR + 1;
            e.v     = v;
            q.push_back(e);
        end
    endtask

    task automatic wait_sb();
        int n;
        n = 0;
        while (q.size() > 0 && n < 6 * FR) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", q.size(), 0);
        q.delete();
    endtask

    initial begin
        vec_t tbl [10];
        vec_t bb1, bb2, xv;
        sb_t  e;
        int   a1, a2, a3, a4, a5, b1, n;

        tbl[0] = '{16'h1234, 4'hF, 1'b0, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'hF};
        tbl[1] = '{16'h00A5, 4'hF, 1'b0, 1'b0, {7'h01, 7'h01, 7'h7F, 7'h24}, 4'hF};
        tbl[2] = '{16'h00A5, 4'hF, 1'b1, 1'b0, {7'h01, 7'h01, 7'h08, 7'h24}, 4'hF};
        tbl[3] = '{16'h0007, 4'hF, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h0F}, 4'h1};
        tbl[4] = '{16'h0007, 4'hF, 1'b0, 1'b0, {7'h01, 7'h01, 7'h01, 7'h0F}, 4'hF};
        tbl[5] = '{16'h3070, 4'h7, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h0F, 7'h01}, 4'h3};
        tbl[6] = '{16'hFEDC, 4'hF, 1'b1, 1'b1, {7'h38, 7'h30, 7'h42, 7'h31}, 4'hF};
        tbl[7] = '{16'hB980, 4'hA, 1'b1, 1'b0, {7'h60, 7'h04, 7'h00, 7'h01}, 4'hA};
        tbl[8] = '{16'h0000, 4'hF, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'h1};
        tbl[9] = '{16'h0690, 4'hF, 1'b0, 1'b1, {7'h7F, 7'h20, 7'h04, 7'h01}, 4'h7};
        bb1    = '{16'h5678, 4'hF, 1'b0, 1'b0, {7'h24, 7'h20, 7'h0F, 7'h00}, 4'hF};
        bb2    = '{16'h8765, 4'hF, 1'b0, 1'b0, {7'h00, 7'h0F, 7'h20, 7'h24}, 4'hF};
        xv     = '{16'h1111, 4'hF, 1'b1, 1'b1, {7'h4F, 7'h4F, 7'h4F, 7'h4F}, 4'hF};

        ifc.wr_valid = 1'b0;
        ifc.wr_data  = '0;
        ifc.wr_mask  = '0;
`ifdef SEG7_DP_EN
        ifc.wr_dp    = '0;
`endif

        // Reset held for three clocks
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_seg", seg_o, 7'h7F);
            chk("reset_an", an_o, 4'hF);
            chk("reset_ready", ifc.wr_ready, 1'b1);
            chk("reset_dp", dp_o, 1'b1);
        end
        rst_n = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            wait_sb();
            hex_mode = tbl[i].hex;
            lz_blank = tbl[i].lz;
            do_write(tbl[i], 1'b1, a1);
        end
        wait_sb();

        // Back-to-back writes: second is held until the first is promoted
        hex_mode = 1'b0;
        lz_blank = 1'b0;
        do_write(bb1, 1'b1, a1);
        b1 = (a1 / FR + 1) * FR;
        do_write(bb2, 1'b1, a2);
        chk("b2b_accept_edge", a2, b1 + 1);
        wait_sb();

        // Write accepted on the boundary edge itself waits a whole frame
        n = 0;
        while ((cyc % FR) != FR - 1 && n < FR + 2) begin
            @(negedge clk);
            n++;
        end
        e.frame = (cyc + 1) / FR;
        e.v     = bb2;
        q.push_back(e);
        do_write(tbl[0], 1'b1, a3);
        chk("boundary_accept_edge", a3 % FR, 0);
        wait_sb();

        // Reset mid-slot while a frame is pending
        hex_mode = 1'b1;
        lz_blank = 1'b1;
        n = 0;
        while ((cyc % FR) != 1 && n < FR + 2) begin
            @(negedge clk);
            n++;
        end
        do_write(xv, 1'b0, a4);
        n = 0;
        while ((cyc % FR) != 12 && n < FR + 2) begin
            @(negedge clk);
            n++;
        end
        chk("pending_before_reset", ifc.wr_ready, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_seg", seg_o, 7'h7F);
        chk("midrst_an", an_o, 4'hF);
        chk("midrst_ready", ifc.wr_ready, 1'b1);
        chk("midrst_dp", dp_o, 1'b1);
        rst_n = 1'b1;
        repeat (FR + DV) begin
            @(negedge clk);
            chk("blank_after_reset_an", an_o, 4'hF);
        end
        do_write(tbl[6], 1'b1, a5);
        wait_sb();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
